// File: rtl/rx_dma_pkg.sv
// Shared types for the RX DMA AXI-stream packer.
//   BYTES_DEF      : default beat width in bytes
//   t_byte_cnt     : byte count for a default-width beat (0..BYTES_DEF)
//   ts_rx_dma_axis : default-width beat payload (data + byte enables)
//   t_pack_state   : packer FSM state
//   keep_to_mask() : byte count -> contiguous low-aligned keep mask
package rx_dma_pkg;

   localparam int BYTES_DEF = 64;

   typedef logic [$clog2(BYTES_DEF):0] t_byte_cnt;

   typedef struct packed {
      logic [BYTES_DEF-1:0][7:0] a64x8_tdata;
      logic [BYTES_DEF-1:0]      v64_tkeep;
   } ts_rx_dma_axis;

   typedef enum logic {
      ACCUM = 1'b0,
      FLUSH = 1'b1
   } t_pack_state;

   function automatic logic [BYTES_DEF-1:0] keep_to_mask(input t_byte_cnt count);
      logic [BYTES_DEF-1:0] m;
      for (int k = 0; k < BYTES_DEF; k++) begin
         m[k] = (k < int'(count));
      end
      return m;
   endfunction

endpackage

// File: rtl/rx_dma_axis_packer_keep_count.sv
// Combinational tkeep decoder.
//   i_keep : byte enables, expected contiguous from bit 0
//   o_cnt  : number of trailing ones (0..BYTES)
//   o_err  : a set bit was found above the first clear bit
module rx_dma_keep_count
   import rx_dma_pkg::*;
#(
   parameter int BYTES = BYTES_DEF
) (
   input  logic [BYTES-1:0]       i_keep,
   output logic [$clog2(BYTES):0] o_cnt,
   output logic                   o_err
);

   localparam int CW = $clog2(BYTES) + 1;

   always_comb begin
      logic seen_zero;
      o_cnt     = '0;
      o_err     = 1'b0;
      seen_zero = 1'b0;
      for (int k = 0; k < BYTES; k++) begin
         if (!i_keep[k]) begin
            seen_zero = 1'b1;
         end else if (seen_zero) begin
            o_err = 1'b1;
         end else begin
            o_cnt = o_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/rx_dma_axis_packer.sv
// RX DMA AXI-stream packer: compacts sparse input beats into dense output
// beats (only the last beat of a packet may be partial) and tracks the
// relative C2H byte write pointer.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_s_* / o_s_tready      : sparse input stream (tkeep contiguous from bit 0)
//   o_m_* / i_m_tready      : packed output stream, registered
//   o_wr_ptr                : bytes handed downstream, modulo 2^PTR_W
//   o_err_keep              : sticky, a non-contiguous input tkeep was seen
module rx_dma_axis_packer
   import rx_dma_pkg::*;
#(
   parameter int BYTES = BYTES_DEF,
   parameter int PTR_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_s_tvalid,
   output logic               o_s_tready,
   input  logic [BYTES*8-1:0] i_s_tdata,
   input  logic [BYTES-1:0]   i_s_tkeep,
   input  logic               i_s_tlast,
   output logic               o_m_tvalid,
   input  logic               i_m_tready,
   output logic [BYTES*8-1:0] o_m_tdata,
   output logic [BYTES-1:0]   o_m_tkeep,
   output logic               o_m_tlast,
   output logic [PTR_W-1:0]   o_wr_ptr,
   output logic               o_err_keep
);

   localparam int CW = $clog2(BYTES) + 1;
   localparam int TW = $clog2(BYTES) + 2;
   localparam int DW = BYTES * 8;

   if ((BYTES < 1) || ((BYTES & (BYTES - 1)) != 0)) begin : gen_bad_bytes
      $error("rx_dma_axis_packer: BYTES must be a power of 2");
   end

   function automatic logic [BYTES-1:0] byte_keep(input logic [TW-1:0] cnt);
      logic [BYTES-1:0] m;
      for (int k = 0; k < BYTES; k++) begin
         m[k] = (k < int'(cnt));
      end
      return m;
   endfunction

   function automatic logic [DW-1:0] keep_to_bits(input logic [BYTES-1:0] keep);
      logic [DW-1:0] b;
      for (int k = 0; k < BYTES; k++) begin
         b[8*k +: 8] = {8{keep[k]}};
      end
      return b;
   endfunction

   t_pack_state      state_q, state_d;
   logic [CW-1:0]    r_q, r_d;
   logic [DW-1:0]    res_q, res_d;
   logic             m_tvalid_q, m_tvalid_d;
   logic [DW-1:0]    m_tdata_q, m_tdata_d;
   logic [BYTES-1:0] m_tkeep_q, m_tkeep_d;
   logic             m_tlast_q, m_tlast_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             err_q, err_d;

   logic [CW-1:0]    in_cnt, out_cnt;
   logic             in_err, out_err;
   logic [TW-1:0]    t;
   logic [DW-1:0]    din;
   logic [2*DW-1:0]  work;
   logic [DW-1:0]    work_lo, work_hi;
   logic             out_free, s_tready, acc, m_hs;

   rx_dma_keep_count #(.BYTES(BYTES)) u_in_cnt (
      .i_keep (i_s_tkeep),
      .o_cnt  (in_cnt),
      .o_err  (in_err)
   );

   // Output keep is contiguous, so trailing-ones count equals popcount.
   rx_dma_keep_count #(.BYTES(BYTES)) u_out_cnt (
      .i_keep (m_tkeep_q),
      .o_cnt  (out_cnt),
      .o_err  (out_err)
   );

   assign out_free = !m_tvalid_q || i_m_tready;
   assign s_tready = !i_rst && (state_q == ACCUM) && out_free;
   assign acc      = i_s_tvalid && s_tready;
   assign m_hs     = m_tvalid_q && i_m_tready;

   // Bytes past the first tkeep hole are dropped before packing; residue bytes
   // at and above r are kept zero so the append can be a plain OR.
   assign t       = TW'(r_q) + TW'(in_cnt);
   assign din     = i_s_tdata & keep_to_bits(byte_keep(TW'(in_cnt)));
   assign work    = {{DW{1'b0}}, res_q} | ({{DW{1'b0}}, din} << {r_q, 3'b000});
   assign work_lo = work[DW-1:0];
   assign work_hi = work[2*DW-1:DW];

   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      res_d      = res_q;
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tkeep_d  = m_tkeep_q;
      m_tlast_d  = m_tlast_q;
      ptr_d      = ptr_q;
      err_d      = err_q;

      if (m_hs) begin
         m_tvalid_d = 1'b0;
         ptr_d      = ptr_q + PTR_W'(out_cnt);
         // Cannot happen with a healthy output register; folded into the
         // sticky flag so a corrupted keep is still visible.
         if (out_err) err_d = 1'b1;
      end

      case (state_q)
         ACCUM: begin
            if (acc) begin
               if (in_err) err_d = 1'b1;
               if (!i_s_tlast) begin
                  if (t >= TW'(BYTES)) begin
                     m_tvalid_d = 1'b1;
                     m_tdata_d  = work_lo;
                     m_tkeep_d  = '1;
                     m_tlast_d  = 1'b0;
                     r_d        = CW'(t - TW'(BYTES));
                     res_d      = work_hi;
                  end else begin
                     r_d   = CW'(t);
                     res_d = work_lo;
                  end
               end else if (t != '0) begin
                  if (t <= TW'(BYTES)) begin
                     m_tvalid_d = 1'b1;
                     m_tdata_d  = work_lo;
                     m_tkeep_d  = byte_keep(t);
                     m_tlast_d  = 1'b1;
                     r_d        = '0;
                     res_d      = '0;
                  end else begin
                     // Packet overflows one beat: emit full beat now, tail next.
                     m_tvalid_d = 1'b1;
                     m_tdata_d  = work_lo;
                     m_tkeep_d  = '1;
                     m_tlast_d  = 1'b0;
                     r_d        = CW'(t - TW'(BYTES));
                     res_d      = work_hi;
                     state_d    = FLUSH;
                  end
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               m_tvalid_d = 1'b1;
               m_tdata_d  = res_q;
               m_tkeep_d  = byte_keep(TW'(r_q));
               m_tlast_d  = 1'b1;
               r_d        = '0;
               res_d      = '0;
               state_d    = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // Stage boundary: output beat, residue and pointer registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ACCUM;
         r_q        <= '0;
         res_q      <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tkeep_q  <= '0;
         m_tlast_q  <= 1'b0;
         ptr_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         res_q      <= res_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tkeep_q  <= m_tkeep_d;
         m_tlast_q  <= m_tlast_d;
         ptr_q      <= ptr_d;
         err_q      <= err_d;
      end
   end

   assign o_s_tready = s_tready;
   assign o_m_tvalid = m_tvalid_q;
   assign o_m_tdata  = m_tdata_q;
   assign o_m_tkeep  = m_tkeep_q;
   assign o_m_tlast  = m_tlast_q;
   assign o_wr_ptr   = ptr_q;
   assign o_err_keep = err_q;

endmodule

// File: tb/tb_rx_dma_axis_packer.sv
module tb_rx_dma_axis_packer;

   localparam int BYTES = 64;
   localparam int PTR_W = 16;
   localparam int DW    = BYTES * 8;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_s_tvalid = 1'b0;
   logic             o_s_tready;
   logic [DW-1:0]    i_s_tdata = '0;
   logic [BYTES-1:0] i_s_tkeep = '0;
   logic             i_s_tlast = 1'b0;
   logic             o_m_tvalid;
   logic             i_m_tready = 1'b1;
   logic [DW-1:0]    o_m_tdata;
   logic [BYTES-1:0] o_m_tkeep;
   logic             o_m_tlast;
   logic [PTR_W-1:0] o_wr_ptr;
   logic             o_err_keep;

   rx_dma_axis_packer #(.BYTES(BYTES), .PTR_W(PTR_W)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_s_tvalid (i_s_tvalid),
      .o_s_tready (o_s_tready),
      .i_s_tdata  (i_s_tdata),
      .i_s_tkeep  (i_s_tkeep),
      .i_s_tlast  (i_s_tlast),
      .o_m_tvalid (o_m_tvalid),
      .i_m_tready (i_m_tready),
      .o_m_tdata  (o_m_tdata),
      .o_m_tkeep  (o_m_tkeep),
      .o_m_tlast  (o_m_tlast),
      .o_wr_ptr   (o_wr_ptr),
      .o_err_keep (o_err_keep)
   );

   always #5 i_clk = ~i_clk;

   int n_vec  = 0;
   int n_miss = 0;
   int nrdy   = 0;

   logic [DW-1:0]    q_d[$];
   logic [BYTES-1:0] q_k[$];
   logic             q_l[$];

   // Beats that will complete on the coming rising edge.
   always @(negedge i_clk) begin
      if (!i_rst && o_m_tvalid && i_m_tready) begin
         q_d.push_back(o_m_tdata);
         q_k.push_back(o_m_tkeep);
         q_l.push_back(o_m_tlast);
      end
      if (!i_rst && !o_s_tready) nrdy <= nrdy + 1;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mkdata(input logic [7:0] base, input int n);
      logic [DW-1:0] d;
      d = '0;
      for (int k = 0; k < BYTES; k++) if (k < n) d[8*k +: 8] = base + 8'(k);
      return d;
   endfunction

   function automatic logic [DW-1:0] mkin(input logic [7:0] base, input int n);
      logic [DW-1:0] d;
      d = mkdata(base, n);
      for (int k = 0; k < BYTES; k++) if (k >= n) d[8*k +: 8] = 8'hEE;
      return d;
   endfunction

   function automatic logic [BYTES-1:0] kn(input int n);
      if (n >= BYTES) return '1;
      return (64'd1 << n) - 64'd1;
   endfunction

   function automatic logic [DW-1:0] bmask(input logic [BYTES-1:0] k);
      logic [DW-1:0] b;
      for (int i = 0; i < BYTES; i++) b[8*i +: 8] = {8{k[i]}};
      return b;
   endfunction

   task automatic exp_beat(input string tag, input int idx, input logic [DW-1:0] d,
                           input logic [BYTES-1:0] k, input logic l);
      if (idx < q_d.size()) begin
         chk({tag, ".keep"}, DW'(q_k[idx]), DW'(k));
         chk({tag, ".data"}, q_d[idx] & bmask(k), d & bmask(k));
         chk({tag, ".last"}, DW'(q_l[idx]), DW'(l));
      end else begin
         chk({tag, ".missing"}, DW'(q_d.size()), DW'(idx + 1));
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [BYTES-1:0] k, input logic l);
      int   cyc;
      logic rdy;
      i_s_tvalid = 1'b1;
      i_s_tdata  = d;
      i_s_tkeep  = k;
      i_s_tlast  = l;
      cyc = 0;
      rdy = 1'b0;
      do begin
         @(negedge i_clk);
         rdy = o_s_tready;
         @(posedge i_clk);
         #1;
         cyc++;
      end while (!rdy && cyc < 200);
      if (!rdy) chk("send_timeout", DW'(cyc), DW'(0));
   endtask

   task automatic idle(input int n);
      i_s_tvalid = 1'b0;
      i_s_tlast  = 1'b0;
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   initial begin
      int qb;
      int rb;
      logic [DW-1:0] x;
      logic [DW-1:0] y;

      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      // Reset state.
      @(negedge i_clk);
      chk("rst.m_tvalid", DW'(o_m_tvalid), DW'(0));
      chk("rst.m_tdata", o_m_tdata, '0);
      chk("rst.m_tkeep", DW'(o_m_tkeep), DW'(0));
      chk("rst.m_tlast", DW'(o_m_tlast), DW'(0));
      chk("rst.wr_ptr", DW'(o_wr_ptr), DW'(0));
      chk("rst.err_keep", DW'(o_err_keep), DW'(0));
      chk("rst.s_tready", DW'(o_s_tready), DW'(1));
      @(posedge i_clk);
      #1;

      // Full beats pass straight through.
      qb = q_d.size();
      rb = nrdy;
      send(mkdata(8'h00, 64), '1, 1'b0);
      send(mkdata(8'h40, 64), '1, 1'b0);
      send(mkdata(8'h80, 64), '1, 1'b1);
      idle(4);
      chk("full.nbeats", DW'(q_d.size() - qb), DW'(3));
      exp_beat("full.b0", qb + 0, mkdata(8'h00, 64), '1, 1'b0);
      exp_beat("full.b1", qb + 1, mkdata(8'h40, 64), '1, 1'b0);
      exp_beat("full.b2", qb + 2, mkdata(8'h80, 64), '1, 1'b1);
      chk("full.wr_ptr", DW'(o_wr_ptr), DW'(192));
      chk("full.stalls", DW'(nrdy - rb), DW'(0));

      // Four 32-byte beats pack into two full beats.
      qb = q_d.size();
      rb = nrdy;
      send(mkin(8'h00, 32), kn(32), 1'b0);
      send(mkin(8'h20, 32), kn(32), 1'b0);
      send(mkin(8'h40, 32), kn(32), 1'b0);
      send(mkin(8'h60, 32), kn(32), 1'b1);
      idle(4);
      chk("pack.nbeats", DW'(q_d.size() - qb), DW'(2));
      exp_beat("pack.b0", qb + 0, mkdata(8'h00, 64), '1, 1'b0);
      exp_beat("pack.b1", qb + 1, mkdata(8'h40, 64), '1, 1'b1);
      chk("pack.wr_ptr", DW'(o_wr_ptr), DW'(320));
      chk("pack.stalls", DW'(nrdy - rb), DW'(0));

      // 40 + 40 bytes with tlast: full beat, then 16-byte flush beat.
      qb = q_d.size();
      rb = nrdy;
      send(mkin(8'h10, 40), kn(40), 1'b0);
      send(mkin(8'h40, 40), kn(40), 1'b1);
      idle(4);
      chk("flush.nbeats", DW'(q_d.size() - qb), DW'(2));
      exp_beat("flush.b0", qb + 0, mkdata(8'h10, 40) | (mkdata(8'h40, 24) << 320), '1, 1'b0);
      exp_beat("flush.b1", qb + 1, mkdata(8'h58, 16), 64'hFFFF, 1'b1);
      chk("flush.stalls", DW'(nrdy - rb), DW'(1));
      chk("flush.wr_ptr", DW'(o_wr_ptr), DW'(400));

      // Output backpressure mid-packet.
      qb = q_d.size();
      x = mkdata(8'h80, 64);
      y = mkdata(8'hC0, 64);
      send(x, '1, 1'b0);
      i_m_tready = 1'b0;
      i_s_tvalid = 1'b1;
      i_s_tdata  = y;
      i_s_tkeep  = '1;
      i_s_tlast  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         chk("bp.hold_valid", DW'(o_m_tvalid), DW'(1));
         chk("bp.hold_data", o_m_tdata, x);
         chk("bp.s_tready", DW'(o_s_tready), DW'(0));
      end
      @(posedge i_clk);
      #1;
      i_m_tready = 1'b1;
      send(y, '1, 1'b1);
      idle(4);
      chk("bp.nbeats", DW'(q_d.size() - qb), DW'(2));
      exp_beat("bp.b0", qb + 0, x, '1, 1'b0);
      exp_beat("bp.b1", qb + 1, y, '1, 1'b1);
      chk("bp.wr_ptr", DW'(o_wr_ptr), DW'(528));

      // Zero-length packet.
      qb = q_d.size();
      send(mkin(8'h00, 0), '0, 1'b1);
      idle(4);
      chk("zlp.nbeats", DW'(q_d.size() - qb), DW'(0));
      chk("zlp.wr_ptr", DW'(o_wr_ptr), DW'(528));

      // Advance the pointer to 0xFFF0, then wrap it.
      for (int b = 0; b < 1015; b++) send(mkdata(8'(b), 64), '1, 1'b0);
      send(mkin(8'h00, 32), kn(32), 1'b1);
      idle(4);
      chk("wrap.pre_ptr", DW'(o_wr_ptr), DW'(16'hFFF0));
      send(mkin(8'h00, 32), kn(32), 1'b1);
      idle(4);
      chk("wrap.wr_ptr", DW'(o_wr_ptr), DW'(16'h0010));
      chk("wrap.err_keep", DW'(o_err_keep), DW'(0));

      // Non-contiguous keep: only the low 4 bytes survive.
      qb = q_d.size();
      send(mkdata(8'h30, 64), 64'h0F0F, 1'b1);
      idle(4);
      chk("err.nbeats", DW'(q_d.size() - qb), DW'(1));
      exp_beat("err.b0", qb, mkdata(8'h30, 4), 64'hF, 1'b1);
      chk("err.err_keep", DW'(o_err_keep), DW'(1));
      chk("err.wr_ptr", DW'(o_wr_ptr), DW'(16'h0014));
      send(mkdata(8'h00, 64), '1, 1'b1);
      idle(4);
      chk("err.sticky", DW'(o_err_keep), DW'(1));
      chk("err.wr_ptr2", DW'(o_wr_ptr), DW'(16'h0054));

      // Reset with 20 bytes of residue pending.
      send(mkin(8'h55, 20), kn(20), 1'b0);
      i_s_tvalid = 1'b0;
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("mrst.m_tvalid", DW'(o_m_tvalid), DW'(0));
      chk("mrst.m_tdata", o_m_tdata, '0);
      chk("mrst.m_tkeep", DW'(o_m_tkeep), DW'(0));
      chk("mrst.m_tlast", DW'(o_m_tlast), DW'(0));
      chk("mrst.wr_ptr", DW'(o_wr_ptr), DW'(0));
      chk("mrst.err_keep", DW'(o_err_keep), DW'(0));
      chk("mrst.s_tready", DW'(o_s_tready), DW'(1));
      @(posedge i_clk);
      #1;
      qb = q_d.size();
      send(mkdata(8'hA0, 64), '1, 1'b1);
      idle(4);
      chk("mrst.nbeats", DW'(q_d.size() - qb), DW'(1));
      exp_beat("mrst.b0", qb, mkdata(8'hA0, 64), '1, 1'b1);
      chk("mrst.wr_ptr2", DW'(o_wr_ptr), DW'(64));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/rx_dma_axis_packer.md
Name: rx_dma_axis_packer

Overview:
- Sits between the RX DMA ingress (sparse 64-byte AXI-stream beats) and the C2H queue slicer (ull_qm_slicer).
- Packs partially filled input beats into fully dense output beats; only the final beat of a packet may be partial.
- Maintains the relative C2H byte write pointer (c2h_wr_ptr_relative) that the slicer consumes on its i_ptr_wr input, zero-extended to 32 bits.

Parameters:
- BYTES, 64, bytes per beat; must be a power of 2, checked at elaboration with $error.
- PTR_W, 16, width of the relative byte write pointer.

Ports:
- i_clk  in  1  clock (PCIe clock domain).
- i_rst  in  1  synchronous, active-high reset.
- i_s_tvalid  in  1  input beat valid.
- o_s_tready  out  1  input beat ready.
- i_s_tdata  in  BYTES*8  input data; byte k is bits [8k+7:8k].
- i_s_tkeep  in  BYTES  input byte enables; must be contiguous from bit 0.
- i_s_tlast  in  1  last beat of the packet.
- o_m_tvalid  out  1  output beat valid.
- i_m_tready  in  1  output beat ready.
- o_m_tdata  out  BYTES*8  packed output data.
- o_m_tkeep  out  BYTES  output byte enables; always contiguous.
- o_m_tlast  out  1  last beat of the packet.
- o_wr_ptr  out  PTR_W  relative byte write pointer.
- o_err_keep  out  1  sticky flag: a non-contiguous tkeep was received.

Behaviour:
- Reset: all outputs are 0, the residue count is 0, and state is ACCUM. Reset mid-packet discards the residue and any pending output; o_s_tready is 1 in the first cycle after reset.
- Handshake: transfer occurs when valid && ready. o_m_* hold stable while o_m_tvalid && !i_m_tready.
- o_s_tready = (state==ACCUM) && (!o_m_tvalid || i_m_tready).
- Byte count: n = number of trailing ones in i_s_tkeep, 0..BYTES. If any tkeep bit above the first zero is set:
  - o_err_keep goes to 1 and stays set until reset;
  - those upper bytes are discarded.
- Residue buffer: holds r bytes, 0..BYTES-1. An accepted beat appends its n bytes at byte offset r, forming a 2*BYTES-byte working vector. Let t = r+n.
- ACCUM, accepted beat, no tlast:
  - t >= BYTES: register a full output beat (bytes 0..BYTES-1, tkeep all ones, tlast 0); r <= t-BYTES, holding the upper bytes.
  - t < BYTES: no output; r <= t.
- ACCUM, accepted beat, tlast:
  - 0 < t <= BYTES: output bytes 0..t-1 with tkeep = 2^t-1 and tlast 1; r <= 0.
  - t > BYTES: output a full beat with tlast 0; r <= t-BYTES; state <= FLUSH.
  - t == 0 (zero-length packet): no output beat, no pointer change.
- FLUSH: o_s_tready is 0. When the output slot frees, register the residue beat (tkeep = 2^r-1, tlast 1); r <= 0; state <= ACCUM.
- Latency: output appears 1 cycle after the completing input handshake (registered output). Throughput is 1 beat/cycle in steady state; there is one stall cycle per packet with t > BYTES on tlast.
- Pointer:
  - On each output handshake, o_wr_ptr <= o_wr_ptr + popcount(o_m_tkeep), modulo 2^PTR_W; wrap-around is silent.
  - The pointer is never updated on input acceptance.
- Simultaneous output handshake and new input beat: both take effect in the same cycle, and the new output beat replaces the old one without a bubble.
- Byte counts are computed on $clog2(BYTES)+1 bits; t uses $clog2(BYTES)+2 bits, so no truncation occurs.

Decomposition:
- Package rx_dma_pkg:
  - the ts_rx_dma_axis packed struct (a64x8_tdata, v64_tkeep);
  - localparam BYTES_DEF = 64;
  - typedef t_byte_cnt;
  - typedef enum {ACCUM, FLUSH} t_pack_state;
  - function automatic keep_to_mask(count).
- Sub-module rx_dma_keep_count (combinational): maps tkeep to trailing-ones count n and a contiguity error bit. It is instantiated twice: once for input count, once for output popcount.

Test Plan (BYTES=64, PTR_W=16):
- Full beats, no gaps: 3 beats with tkeep all ones, last beat tlast 1. Expected: 3 identical output beats, third with tlast 1; o_wr_ptr = 192; no stall cycles.
- Packing: 4 beats of 32 bytes each (tkeep=2^32-1, data 0x00..0x7F), last beat tlast 1. Expected: 2 full output beats carrying bytes 0x00..0x7F in order; second beat tlast 1; o_wr_ptr = 128.
- Two-beat flush: a 40-byte beat, then a 40-byte beat with tlast 1. Expected:
  - a full 64-byte beat (tlast 0), then a 16-byte beat (tkeep=0xFFFF, tlast 1);
  - o_s_tready is 0 for exactly 1 cycle;
  - o_wr_ptr = 80.
- Backpressure and zero-length packet: hold i_m_tready=0 for 5 cycles mid-packet. Expected: o_m_* stable, o_s_tready is 0, no data loss. Then send tkeep=0 with tlast 1 and r=0. Expected: no output beat and no pointer change.
- Wrap and error:
  - preload traffic so o_wr_ptr=0xFFF0, then send a 32-byte tlast packet. Expected: o_wr_ptr=0x0010.
  - send tkeep=0x...0F0F. Expected: n=4, o_err_keep goes to 1 and stays set.
- Reset mid-packet: assert i_rst with r=20. Expected: next cycle outputs are all 0 and r=0; a new 64-byte beat is passed through unshifted.
